// File: rtl/rr_arbiter_pkg.sv
// Shared helpers for the round-robin arbiter: index and quantum-counter widths.
package rr_arbiter_pkg;

  // Width of a requester index; at least one bit even for tiny N.
  function automatic int rr_idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of a counter holding 0..q-1; at least one bit.
  function automatic int rr_qw(input int q);
    return (q <= 2) ? 1 : $clog2(q);
  endfunction

endpackage

// File: rtl/rr_arbiter_n_pick.sv
// Combinational round-robin picker: rotate the request vector so that ptr sits at
// bit 0, take the lowest set bit, then rotate the result back to absolute index.
module rr_pick
  import rr_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = rr_idw(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] idx,
  output logic           any
);

  logic [N-1:0] rot;
  int           k;
  int           sum;

  // Rotate, priority-encode and rotate back; modulo arithmetic keeps idx < N.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    rot    = '0;
    k      = 0;
    sum    = 0;
    onehot = '0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req[(i + int'(ptr)) % N];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) k = i;
    end
    any = |rot;
    sum = k + int'(ptr);
    if (sum >= N) sum = sum - N;
    if (any) begin
      idx    = IDW'(sum);
      onehot = N'(1) << sum;
    end
  end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with grant quantum and rotating priority pointer.
// Optional lock input enabled by defining RR_ARBITER_LOCK_EN.
module rr_arbiter_n
  import rr_arbiter_pkg::*;
#(
  parameter int N       = 4,
  parameter int QUANTUM = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [N-1:0]        ir,
`ifdef RR_ARBITER_LOCK_EN
  input  logic                lock,
`endif
  output logic [N-1:0]        ack,
  output logic                ack_valid,
  output logic [rr_idw(N)-1:0] ack_id
);

  localparam int IDW = rr_idw(N);
  localparam int QW  = rr_qw(QUANTUM);
  typedef logic [QW-1:0] qcnt_t;
  localparam qcnt_t QMAX = qcnt_t'(QUANTUM - 1);

  logic [N-1:0]   req_q, req_d;
  logic [N-1:0]   ack_q, ack_d;
  logic           ack_valid_q, ack_valid_d;
  logic [IDW-1:0] ack_id_q, ack_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  qcnt_t          qcnt_q, qcnt_d;
  logic           lock_hold;

  logic [N-1:0]   pick_onehot;
  logic [IDW-1:0] pick_idx;
  logic           pick_any;
  logic           others;
  logic           keep;

`ifdef RR_ARBITER_LOCK_EN
  logic lock_q;

  // Lock is latched on the same edge as the requests so both are seen together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) lock_q <= 1'b0;
    else          lock_q <= lock;
  end
  assign lock_hold = lock_q;
`else
  assign lock_hold = 1'b0;
`endif

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req    (req_q),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Next-state: idle, keep the current grantee, or rotate to the next winner.
  always_comb begin
    req_d       = ir;
    ack_d       = ack_q;
    ack_valid_d = ack_valid_q;
    ack_id_d    = ack_id_q;
    ptr_d       = ptr_q;
    qcnt_d      = qcnt_q;
    others      = |(req_q & ~ack_q);
    keep        = ack_valid_q && req_q[ack_id_q] &&
                  (!others || lock_hold || (qcnt_q < QMAX));
    if (!pick_any) begin
      ack_d       = '0;
      ack_valid_d = 1'b0;
    end else if (keep) begin
      if (qcnt_q < QMAX) qcnt_d = qcnt_q + 1'b1;
    end else begin
      ack_d       = pick_onehot;
      ack_valid_d = 1'b1;
      ack_id_d    = pick_idx;
      qcnt_d      = '0;
      ptr_d       = (pick_idx == IDW'(N - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_q       <= '0;
      ack_q       <= '0;
      ack_valid_q <= 1'b0;
      ack_id_q    <= '0;
      ptr_q       <= '0;
      qcnt_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      req_q       <= req_d;
      ack_q       <= ack_d;
      ack_valid_q <= ack_valid_d;
      ack_id_q    <= ack_id_d;
      ptr_q       <= ptr_d;
      qcnt_q      <= qcnt_d;
    end
  end

  assign ack       = ack_q;
  assign ack_valid = ack_valid_q;
  assign ack_id    = ack_id_q;

  a_onehot: assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0(ack_q));
  a_valid: assert property (@(posedge clock) disable iff (!reset_n)
    ack_valid_q == (|ack_q));
  a_from_req: assert property (@(posedge clock) disable iff (!reset_n)
    (ack_q & ~$past(req_q)) == '0);
  a_single: assert property (@(posedge clock) disable iff (!reset_n)
    $onehot(req_q) |=> (ack_q == $past(req_q)));
  a_idle: assert property (@(posedge clock) disable iff (!reset_n)
    (req_q == '0) |=> (ack_q == '0));

`ifndef SYNTHESIS
`ifndef RR_ARBITER_LOCK_EN
  localparam int unsigned STARVE_MAX = (N - 1) * QUANTUM + 1;
  int unsigned wait_q [N];

  // Count consecutive cycles each requester is held without being granted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) wait_q[i] <= 0;
    end else begin
      for (int i = 0; i < N; i++)
        wait_q[i] <= (req_q[i] && !ack_q[i]) ? wait_q[i] + 1 : 0;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_starve
    a_starve: assert property (@(posedge clock) disable iff (!reset_n)
      wait_q[gi] <= STARVE_MAX);
  end
`endif
`endif

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Scoreboard bench for rr_arbiter_n (N=4, QUANTUM=2; plus N=3, QUANTUM=1 lock
// scenario when RR_ARBITER_LOCK_EN is defined).
module tb_rr_arbiter_n;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] ir4 = 4'b0000;
  logic [3:0] ack4;
  logic       valid4;
  logic [1:0] id4;
  logic       lock_done = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;

  typedef struct {
    logic [3:0] ack;
    logic [1:0] id;
    string      name;
  } exp_t;

  exp_t sb4[$];

  always #5 clock = ~clock;

`ifdef RR_ARBITER_LOCK_EN
  logic lock4 = 1'b0;
`endif

  rr_arbiter_n #(.N(4), .QUANTUM(2)) dut4 (
    .clock     (clock),
    .reset_n   (reset_n),
    .ir        (ir4),
`ifdef RR_ARBITER_LOCK_EN
    .lock      (lock4),
`endif
    .ack       (ack4),
    .ack_valid (valid4),
    .ack_id    (id4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one raw request vector and queue the outputs expected after the next edge.
  task automatic drive4(input logic [3:0] v, input logic [3:0] ea, input logic [1:0] eid,
                        input string nm);
    ir4 = v;
    sb4.push_back('{ack: ea, id: eid, name: nm});
    @(negedge clock);
  endtask

  // Monitor: compare {ack, ack_valid, ack_id} shortly after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb4.size() != 0) begin
        e = sb4.pop_front();
        check(e.name, {25'd0, ack4, valid4, id4}, {25'd0, e.ack, |e.ack, e.id});
      end
    end
  end

`ifdef RR_ARBITER_LOCK_EN
  logic [2:0] ir3 = 3'b000;
  logic       lock3 = 1'b0;
  logic [2:0] ack3;
  logic       valid3;
  logic [1:0] id3;
  exp_t       sb3[$];

  rr_arbiter_n #(.N(3), .QUANTUM(1)) dut3 (
    .clock     (clock),
    .reset_n   (reset_n),
    .ir        (ir3),
    .lock      (lock3),
    .ack       (ack3),
    .ack_valid (valid3),
    .ack_id    (id3)
  );

  task automatic drive3(input logic [2:0] v, input logic lk, input logic [2:0] ea,
                        input logic [1:0] eid, input string nm);
    ir3   = v;
    lock3 = lk;
    sb3.push_back('{ack: {1'b0, ea}, id: eid, name: nm});
    @(negedge clock);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb3.size() != 0) begin
        e = sb3.pop_front();
        check(e.name, {26'd0, ack3, valid3, id3}, {26'd0, e.ack[2:0], |e.ack, e.id});
      end
    end
  end

  initial begin
    ir3 = 3'b111;
    @(posedge reset_n);
    drive3(3'b111, 1'b0, 3'b000, 2'd0, "lk_first_edge");
    drive3(3'b111, 1'b0, 3'b001, 2'd0, "lk_g0");
    drive3(3'b111, 1'b0, 3'b010, 2'd1, "lk_g1");
    drive3(3'b111, 1'b1, 3'b100, 2'd2, "lk_g2");
    drive3(3'b111, 1'b1, 3'b100, 2'd2, "lk_hold_a");
    drive3(3'b111, 1'b1, 3'b100, 2'd2, "lk_hold_b");
    drive3(3'b111, 1'b0, 3'b100, 2'd2, "lk_hold_c");
    drive3(3'b111, 1'b0, 3'b001, 2'd0, "lk_wrap_0");
    drive3(3'b111, 1'b0, 3'b010, 2'd1, "lk_g1_again");
    @(negedge clock);
    check("lk_sb_drained", sb3.size(), 0);
    lock_done = 1'b1;
  end
`else
  initial lock_done = 1'b1;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    ir4 = 4'b1111;
    #1 reset_n = 1'b0;
    #1 check("reset_state", {25'd0, ack4, valid4, id4}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // All four requesting: two cycles each, 0,0,1,1,2,2,3,3,0.
    drive4(4'b1111, 4'b0000, 2'd0, "first_edge");
    drive4(4'b1111, 4'b0001, 2'd0, "rr_g0a");
    drive4(4'b1111, 4'b0001, 2'd0, "rr_g0b");
    drive4(4'b1111, 4'b0010, 2'd1, "rr_g1a");
    drive4(4'b1111, 4'b0010, 2'd1, "rr_g1b");
    drive4(4'b1111, 4'b0100, 2'd2, "rr_g2a");
    drive4(4'b1111, 4'b0100, 2'd2, "rr_g2b");
    drive4(4'b1111, 4'b1000, 2'd3, "rr_g3a");
    drive4(4'b1111, 4'b1000, 2'd3, "rr_g3b");
    drive4(4'b1111, 4'b0001, 2'd0, "rr_wrap_g0");

    // Only requester 2: grantee 0 finishes its quantum, then 2 holds continuously.
    drive4(4'b0100, 4'b0001, 2'd0, "solo_tail_g0");
    for (int i = 0; i < 9; i++) drive4(4'b0100, 4'b0100, 2'd2, "solo_g2");

    // Grantee 1 drops its request mid-quantum; scan from ptr=2 finds 3, not 0.
    drive4(4'b0010, 4'b0100, 2'd2, "solo_g2_last");
    drive4(4'b1001, 4'b0010, 2'd1, "grant_1");
    drive4(4'b0000, 4'b1000, 2'd3, "drop_to_3");

    // Requests removed: grant clears, ack_id holds.
    drive4(4'b0000, 4'b0000, 2'd3, "idle_a");
    drive4(4'b1010, 4'b0000, 2'd3, "idle_hold_id");
    drive4(4'b1010, 4'b0010, 2'd1, "pre_reset_g1");

    // Asynchronous reset between edges while 1 is granted.
    #2 reset_n = 1'b0;
    #1 check("async_reset", {25'd0, ack4, valid4, id4}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // After reset ptr=0, so 1 wins ahead of 3; then rotate 3 and wrap back to 1.
    drive4(4'b1010, 4'b0000, 2'd0, "post_reset_edge");
    drive4(4'b1010, 4'b0010, 2'd1, "post_reset_win1");
    drive4(4'b1010, 4'b0010, 2'd1, "quantum_hold1");
    drive4(4'b1010, 4'b1000, 2'd3, "quantum_expire3");
    drive4(4'b1010, 4'b1000, 2'd3, "quantum_hold3");
    drive4(4'b1010, 4'b0010, 2'd1, "wrap_to1");

    @(negedge clock);
    check("sb_drained", sb4.size(), 0);
    wait (lock_done);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
